// File: rtl/subtractor_borrow_serial_amisha.sv
// rtl/subtractor_borrow_serial_amisha.sv - bit-serial N-bit unsigned subtractor with borrow out
//
// Computes diff = (a - b) mod 2^N one bit per clock, LSB first, behind a
// start/busy/done handshake. An accepted start loads the operands. N bit-steps
// follow. The completion edge then updates diff/bout/zero together and raises
// done for one cycle. A start seen in DONE is accepted immediately, so
// back-to-back operations complete every N+1 cycles.
//
// Optional feature macro: SUB_SIGNED_OVF_EN
//   When defined, adds ovf_amisha. This is the two's-complement overflow of
//   the captured operands, registered with diff.
//
// Ports:
//   clk_amisha    in   1  clock, rising edge
//   rst_n_amisha  in   1  asynchronous active-low reset
//   start_amisha  in   1  operation request, sampled only when not busy
//   a_amisha      in   N  minuend, captured on accepted start
//   b_amisha      in   N  subtrahend, captured on accepted start
//   diff_amisha   out  N  registered (a - b) mod 2^N
//   bout_amisha   out  1  registered borrow out (a < b unsigned)
//   zero_amisha   out  1  registered, diff == 0
//   busy_amisha   out  1  high while bit-steps are in progress
//   done_amisha   out  1  one-cycle pulse after results update
//   ovf_amisha    out  1  signed overflow (SUB_SIGNED_OVF_EN only)

module subtractor_borrow_serial_amisha #(
    parameter int N  = 4,
    parameter int N1 = N - 1
) (
    input  logic         clk_amisha,
    input  logic         rst_n_amisha,
    input  logic         start_amisha,
    input  logic [N-1:0] a_amisha,
    input  logic [N-1:0] b_amisha,
    output logic [N-1:0] diff_amisha,
    output logic         bout_amisha,
    output logic         zero_amisha,
    output logic         busy_amisha,
`ifdef SUB_SIGNED_OVF_EN
    output logic         done_amisha,
    output logic         ovf_amisha
`else
    output logic         done_amisha
`endif
);

    // The counter holds the step index 0..N-1. Completion is detected on the
    // last index, so the counter never has to represent N and never wraps.
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-1:0]  res_sr;
    logic          borrow;
    logic [CW-1:0] count;

    logic          bit_i;
    logic          bit_j;
    logic          bit_d;
    logic          borrow_nxt;
    logic [N-1:0]  res_nxt;
    logic          last_step;

    // Full-subtractor step on the current LSBs of the operand shift registers.
    always_comb begin
        bit_i      = a_sr[0];
        bit_j      = b_sr[0];
        bit_d      = bit_i ^ bit_j ^ borrow;
        borrow_nxt = (~bit_i & bit_j) | (~(bit_i ^ bit_j) & borrow);
        // Difference bits enter from the MSB side. After N steps the first
        // (LSB) difference bit has reached position 0.
        res_nxt    = {bit_d, res_sr[N1:1]};
        last_step  = (count == LAST_STEP);
    end

    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            state       <= IDLE;
            a_sr        <= '0;
            b_sr        <= '0;
            res_sr      <= '0;
            borrow      <= 1'b0;
            count       <= '0;
            diff_amisha <= '0;
            bout_amisha <= 1'b0;
            zero_amisha <= 1'b0;
            busy_amisha <= 1'b0;
            done_amisha <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            ovf_amisha  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_amisha <= 1'b0;
                    if (start_amisha) begin
                        a_sr        <= a_amisha;
                        b_sr        <= b_amisha;
                        res_sr      <= '0;
                        borrow      <= 1'b0;
                        count       <= '0;
                        busy_amisha <= 1'b1;
                        state       <= RUN;
                    end else begin
                        state       <= IDLE;
                    end
                end

                RUN: begin
                    // The start input is not looked at here. Requests made
                    // while busy are dropped and the operation continues.
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nxt;
                    borrow <= borrow_nxt;
                    if (last_step) begin
                        diff_amisha <= res_nxt;
                        bout_amisha <= borrow_nxt;
                        zero_amisha <= (res_nxt == '0);
`ifdef SUB_SIGNED_OVF_EN
                        // On the last step the operand LSBs are the captured
                        // sign bits and bit_d is the result sign bit.
                        ovf_amisha  <= (bit_i != bit_j) && (bit_d != bit_i);
`endif
                        done_amisha <= 1'b1;
                        busy_amisha <= 1'b0;
                        count       <= '0;
                        state       <= DONE;
                    end else begin
                        count       <= count + CW'(1);
                    end
                end

                default: begin
                    busy_amisha <= 1'b0;
                    done_amisha <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subtractor_borrow_serial_amisha.sv
// tb/tb_subtractor_borrow_serial_amisha.sv - self-checking bench for the bit-serial subtractor

module tb_subtractor_borrow_serial_amisha;

    logic       clk;
    logic       rst_n;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic [3:0] diff4;
    logic       bout4;
    logic       zero4;
    logic       busy4;
    logic       done4;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic [7:0] diff8;
    logic       bout8;
    logic       zero8;
    logic       busy8;
    logic       done8;

`ifdef SUB_SIGNED_OVF_EN
    logic       ovf4;
    logic       ovf8;
`endif

    int errors = 0;
    int checks = 0;

    subtractor_borrow_serial_amisha #(.N(4)) u_dut4 (
        .clk_amisha   (clk),
        .rst_n_amisha (rst_n),
        .start_amisha (start4),
        .a_amisha     (a4),
        .b_amisha     (b4),
        .diff_amisha  (diff4),
        .bout_amisha  (bout4),
        .zero_amisha  (zero4),
        .busy_amisha  (busy4),
`ifdef SUB_SIGNED_OVF_EN
        .done_amisha  (done4),
        .ovf_amisha   (ovf4)
`else
        .done_amisha  (done4)
`endif
    );

    subtractor_borrow_serial_amisha #(.N(8)) u_dut8 (
        .clk_amisha   (clk),
        .rst_n_amisha (rst_n),
        .start_amisha (start8),
        .a_amisha     (a8),
        .b_amisha     (b8),
        .diff_amisha  (diff8),
        .bout_amisha  (bout8),
        .zero_amisha  (zero8),
        .busy_amisha  (busy8),
`ifdef SUB_SIGNED_OVF_EN
        .done_amisha  (done8),
        .ovf_amisha   (ovf8)
`else
        .done_amisha  (done8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        checks++;
        if ({diff4, bout4, zero4, busy4, done4} !== 8'h00) begin
            errors++;
            $display("FAIL reset_dut4: got %b expected 00000000", {diff4, bout4, zero4, busy4, done4});
        end
        checks++;
        if ({diff8, bout8, zero8, busy8, done8} !== 12'h000) begin
            errors++;
            $display("FAIL reset_dut8: got %b expected 000000000000", {diff8, bout8, zero8, busy8, done8});
        end
`ifdef SUB_SIGNED_OVF_EN
        checks++;
        if ({ovf4, ovf8} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ovf: got %b expected 00", {ovf4, ovf8});
        end
`endif
    endtask

    // One complete operation on the N=4 instance, with hand-computed expectations.
    task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] exp_d,
                           input logic exp_bo, input logic exp_z, input logic exp_ovf,
                           input string name);
        logic [3:0] prev_d;
        int cyc;
        int busy_cnt;
        bit unstable;
        prev_d   = diff4;
        a4       = a;
        b4       = b;
        start4   = 1'b1;
        @(posedge clk); #1;
        start4   = 1'b0;
        a4       = ~a;
        b4       = ~b;
        cyc      = 0;
        busy_cnt = 0;
        unstable = 1'b0;
        while (!done4 && cyc < 20) begin
            if (busy4) busy_cnt++;
            if (diff4 !== prev_d) unstable = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== 4) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles expected 4", name, cyc);
        end
        checks++;
        if (busy_cnt !== 4) begin
            errors++;
            $display("FAIL %s busy_len: got %0d expected 4", name, busy_cnt);
        end
        checks++;
        if (unstable) begin
            errors++;
            $display("FAIL %s diff_stable: got changing diff expected held %0d", name, prev_d);
        end
        checks++;
        if ({diff4, bout4, zero4, busy4} !== {exp_d, exp_bo, exp_z, 1'b0}) begin
            errors++;
            $display("FAIL %s result: got diff=%0d bout=%b zero=%b busy=%b expected diff=%0d bout=%b zero=%b busy=0",
                     name, diff4, bout4, zero4, busy4, exp_d, exp_bo, exp_z);
        end
`ifdef SUB_SIGNED_OVF_EN
        checks++;
        if (ovf4 !== exp_ovf) begin
            errors++;
            $display("FAIL %s ovf: got %b expected %b", name, ovf4, exp_ovf);
        end
`else
        if (exp_ovf === 1'bx) $display("note: %s has unknown ovf expectation", name);
`endif
        @(posedge clk); #1;
        checks++;
        if ({done4, busy4, diff4} !== {1'b0, 1'b0, exp_d}) begin
            errors++;
            $display("FAIL %s after_done: got done=%b busy=%b diff=%0d expected done=0 busy=0 diff=%0d",
                     name, done4, busy4, diff4, exp_d);
        end
    endtask

    task automatic test_basic();
        run_op4(4'd9, 4'd3, 4'd6,  1'b0, 1'b0, 1'b1, "sub_9_3");
        run_op4(4'd3, 4'd9, 4'hA,  1'b1, 1'b0, 1'b1, "sub_3_9");
        run_op4(4'd7, 4'd7, 4'd0,  1'b0, 1'b1, 1'b0, "sub_7_7");
        run_op4(4'd0, 4'd15, 4'd1, 1'b1, 1'b0, 1'b0, "sub_0_15");
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit busy_seen;
        a4     = 4'd5;
        b4     = 4'd2;
        start4 = 1'b1;
        @(posedge clk); #1;
        a4     = 4'd2;
        b4     = 4'd5;
        cyc    = 0;
        while (!done4 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if ({cyc[3:0], diff4, bout4} !== {4'd4, 4'd3, 1'b0}) begin
            errors++;
            $display("FAIL b2b_first: got cyc=%0d diff=%0d bout=%b expected cyc=4 diff=3 bout=0", cyc, diff4, bout4);
        end
        cyc       = 0;
        busy_seen = 1'b0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) busy_seen = busy4;
        end while (!done4 && cyc < 20);
        checks++;
        if (busy_seen !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b after DONE with start expected 1", busy_seen);
        end
        checks++;
        if ({cyc[3:0], diff4, bout4, zero4} !== {4'd5, 4'd13, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_second: got cyc=%0d diff=%0d bout=%b zero=%b expected cyc=5 diff=13 bout=1 zero=0",
                     cyc, diff4, bout4, zero4);
        end
        start4 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({done4, busy4} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_idle: got done=%b busy=%b expected 0 0", done4, busy4);
        end
    endtask

    task automatic test_reset_mid_run();
        bit done_seen;
        a4     = 4'd9;
        b4     = 4'd3;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({diff4, bout4, zero4, busy4, done4} !== 8'h00) begin
            errors++;
            $display("FAIL midrun_reset: got %b expected 00000000", {diff4, bout4, zero4, busy4, done4});
        end
        done_seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (done4) done_seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done4 || busy4) done_seen = 1'b1;
        end
        checks++;
        if (done_seen) begin
            errors++;
            $display("FAIL midrun_no_done: got done/busy activity expected none");
        end
        run_op4(4'd9, 4'd3, 4'd6, 1'b0, 1'b0, 1'b1, "after_reset_9_3");
    endtask

    task automatic test_ovf();
        run_op4(4'd8, 4'd1,  4'd7, 1'b0, 1'b0, 1'b1, "ovf_8_1");
        run_op4(4'd7, 4'd15, 4'd8, 1'b1, 1'b0, 1'b1, "ovf_7_15");
        run_op4(4'd5, 4'd3,  4'd2, 1'b0, 1'b0, 1'b0, "ovf_5_3");
    endtask

    task automatic test_wide_random();
        logic [8:0] ref_r;
        logic [7:0] ra;
        logic [7:0] rb;
        int cyc;
        for (int n = 0; n < 1000; n++) begin
            case (n)
                0:       begin ra = 8'd0;   rb = 8'd255; end
                1:       begin ra = 8'd255; rb = 8'd0;   end
                2:       begin ra = 8'd170; rb = 8'd170; end
                3:       begin ra = 8'd128; rb = 8'd1;   end
                default: begin ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255)); end
            endcase
            ref_r  = {1'b0, ra} - {1'b0, rb};
            a8     = ra;
            b8     = rb;
            start8 = 1'b1;
            @(posedge clk); #1;
            start8 = 1'b0;
            cyc    = 0;
            while (!done8 && cyc < 30) begin
                @(posedge clk); #1;
                cyc++;
            end
            checks++;
            if (cyc !== 8) begin
                errors++;
                $display("FAIL n8_latency op%0d: got %0d cycles expected 8", n, cyc);
            end
            checks++;
            if ({diff8, bout8, zero8} !== {ref_r[7:0], ref_r[8], ref_r[7:0] == 8'd0}) begin
                errors++;
                $display("FAIL n8_result op%0d a=%0d b=%0d: got diff=%0d bout=%b zero=%b expected diff=%0d bout=%b zero=%b",
                         n, ra, rb, diff8, bout8, zero8, ref_r[7:0], ref_r[8], ref_r[7:0] == 8'd0);
            end
`ifdef SUB_SIGNED_OVF_EN
            checks++;
            if (ovf8 !== ((ra[7] != rb[7]) && (ref_r[7] != ra[7]))) begin
                errors++;
                $display("FAIL n8_ovf op%0d a=%0d b=%0d: got %b", n, ra, rb, ovf8);
            end
`endif
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start4 = 1'b0;
        a4     = '0;
        b4     = '0;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_back_to_back();
        test_reset_mid_run();
        test_ovf();
        test_wide_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
